vproc_cache_arbiter: RTL
========================

Name: vproc_cache_arbiter

Overview:
- Shares the single CPU-side port of the vproc data cache between NUM_REQ requesters, e.g. the vector load/store unit and the scalar core's data port.
- Each cycle it selects one requester by round-robin and forwards that requester's request to the cache.
- It records the requester ID of every granted transaction in an in-order ID FIFO. Each cache response (rvalid/rdata/err) is routed back to the ID at the FIFO head.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
ADDR_BIT_W, 16, address width (bits)
CPU_BYTE_W, 4, data width (bytes)
MAX_OUTSTANDING, 4, ID FIFO depth (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-requester request
addr_i  in  NUM_REQ*ADDR_BIT_W  per-requester address (requester i at slice i)
we_i  in  NUM_REQ  per-requester write enable
be_i  in  NUM_REQ*CPU_BYTE_W  per-requester byte enable
wdata_i  in  NUM_REQ*CPU_BYTE_W*8  per-requester write data
gnt_o  out  NUM_REQ  per-requester grant
rvalid_o  out  NUM_REQ  per-requester response valid
rdata_o  out  CPU_BYTE_W*8  response data, shared by all requesters
err_o  out  1  response error, shared by all requesters
cache_req_o  out  1  request to cache
cache_addr_o  out  ADDR_BIT_W  request address to cache
cache_we_o  out  1  request write enable to cache
cache_be_o  out  CPU_BYTE_W  request byte enable to cache
cache_wdata_o  out  CPU_BYTE_W*8  request write data to cache
cache_gnt_i  in  1  cache grant
cache_rvalid_i  in  1  cache response valid
cache_rdata_i  in  CPU_BYTE_W*8  cache response data
cache_err_i  in  1  cache response error
perf_gnt_cnt_o  out  NUM_REQ*32  per-requester grant counters (optional feature)

Behaviour:
- Reset values: rr_q=0, FIFO empty (rd/wr pointers 0, count 0), perf counters 0.
  - All of gnt_o, rvalid_o and cache_req_o are 0 during and after reset while inputs are idle.
- Protocol is OBI-like. A requester holds req_i and its payload stable until gnt_o is seen.
- Selection is combinational.
  - sel = first i with req_i[i]=1, scanning i = rr_q, rr_q+1, ..., wrapping modulo NUM_REQ.
  - sel does not depend on cache_gnt_i, so there is no combinational loop.
- cache_req_o = |req_i & ~fifo_full.
- cache_addr_o, cache_we_o, cache_be_o and cache_wdata_o carry requester sel's payload. They are don't-care when cache_req_o=0.
- gnt_o[i] = cache_req_o & cache_gnt_i & (sel==i). At most one bit is set per cycle; zero-latency grant passthrough.
- On a grant (handshake):
  - push sel into the FIFO;
  - rr_q <= (sel+1) mod NUM_REQ.
  - With no handshake, rr_q holds. An ungranted requester therefore keeps top priority.
- Every granted transaction, read or write, produces exactly one cache_rvalid_i, in grant order.
  - On cache_rvalid_i: pop the head; rvalid_o[head]=1 in the same cycle. rdata_o and err_o pass cache_rdata_i and cache_err_i through combinationally.
  - rvalid_o is 0 for all requesters otherwise.
- Full: no new grants (cache_req_o=0).
  - A pop in the same cycle does not enable a push; the push waits one cycle.
  - Throughput is unaffected when MAX_OUTSTANDING exceeds the cache's hit pipeline depth.
- Empty with cache_rvalid_i=1: protocol violation. The response is dropped and all rvalid_o stay 0. A simulation assertion fires.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - Push while empty never coincides with a pop: the cache response lags its grant by at least 1 cycle.
- Pointers wrap modulo MAX_OUTSTANDING. The count is one bit wider than the pointers to separate full from empty.
- Reset mid-operation clears the FIFO and rr_q. Responses still in flight from the cache after reset are dropped (empty rule).
  - Reset of the arbiter therefore requires the cache to be reset too.

Optional Feature:
- Macro: VPROC_CACHE_ARB_PERF_EN.
- Defined: per-requester 32-bit counter, incremented on each gnt_o[i]. The counter wraps at 2^32 and is reset to 0 by rst_ni. Output on perf_gnt_cnt_o.
- Not defined: no counter registers; perf_gnt_cnt_o tied to 0.

Decomposition:
- Package vproc_cache_arb_pkg:
  - function rr_select (NUM_REQ-wide round-robin priority pick);
  - localparam-derived widths: ID_W=$clog2(NUM_REQ), PTR_W=$clog2(MAX_OUTSTANDING).
- Sub-module vproc_cache_arb_idfifo: synchronous FIFO of ID_W-bit entries with push/pop/full/empty, async active-low reset.

Test Plan:
- Req0 alone reads addr 0x0040, cache_gnt_i=1, rvalid 2 cycles later with rdata 0xDEADBEEF -> gnt_o=01 same cycle; rvalid_o=01 with rdata_o=0xDEADBEEF; rvalid_o[1] stays 0.
- Both requesters held for 4 granted cycles, rr_q=0 at start -> gnt order 0,1,0,1. Responses in order, routed to rvalid_o=01,10,01,10.
- cache_gnt_i=0 for 3 cycles with req_i=11, rr_q=1 -> sel stays 1, no gnt_o. rr_q unchanged; when gnt returns, gnt_o=10.
- MAX_OUTSTANDING=4, no cache_rvalid_i, req0 constant -> 4 grants then cache_req_o=0. One rvalid pops, and the next cycle cache_req_o=1 again.
- Write grant from req1 followed by a cache_rvalid_i with cache_err_i=1 -> rvalid_o=10, err_o=1. FIFO returns to empty.
- Assert rst_ni low with 3 outstanding, then inject cache_rvalid_i -> no rvalid_o. With PERF_EN defined, counters read 0 after reset and increment per grant.

Source files
------------

// File: rtl/vproc_cache_arb_pkg.sv
// Shared types, widths and helpers for the vproc cache-port arbiter.
// Contents:
//   NUM_REQ_DEF / MAX_OUTSTANDING_DEF   default configuration
//   ID_W / PTR_W                        widths derived from the defaults
//   rr_select()                         round-robin priority pick over a request vector
package vproc_cache_arb_pkg;

  localparam int unsigned NUM_REQ_DEF         = 2;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  localparam int unsigned ID_W  = $clog2(NUM_REQ_DEF);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING_DEF);

  // Upper bound on requesters handled by rr_select; callers zero-extend req.
  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;

  // First index with req set, scanning rr, rr+1, ... modulo num_req.
  // Returns 0 when nothing is requested (caller qualifies with |req).
  function automatic logic [RR_IDX_W-1:0] rr_select(input logic [RR_MAX_REQ-1:0] req,
                                                    input int unsigned           num_req,
                                                    input int unsigned           rr);
    logic        found;
    int unsigned idx;
    rr_select = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req) begin
        idx = rr + k;
        if (idx >= num_req) idx = idx - num_req;
        if (!found && req[RR_IDX_W'(idx)]) begin
          found     = 1'b1;
          rr_select = RR_IDX_W'(idx);
        end
      end
    end
  endfunction

endpackage

// File: rtl/vproc_cache_arb_idfifo.sv
// In-order FIFO of requester IDs for outstanding cache transactions.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   push_i, data_i     enqueue an ID (ignored when full)
//   pop_i, data_o      dequeue head ID (ignored when empty); data_o is the head
//   full_o, empty_o    occupancy flags
module vproc_cache_arb_idfifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vproc_cache_arbiter.sv
// Round-robin arbiter sharing the vproc data cache CPU port between NUM_REQ
// requesters; responses are routed back in grant order via an ID FIFO.
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   req_i/addr_i/we_i/be_i/wdata_i      per-requester OBI-like request (slice i = requester i)
//   gnt_o, rvalid_o                     per-requester grant / response valid
//   rdata_o, err_o                      shared response data / error
//   cache_*_o, cache_gnt_i              request side towards the cache
//   cache_rvalid_i/rdata_i/err_i        response side from the cache
//   perf_gnt_cnt_o                      per-requester 32-bit grant counters
// Optional build macro VPROC_CACHE_ARB_PERF_EN enables the grant counters;
// without it perf_gnt_cnt_o is tied to zero.
module vproc_cache_arbiter
  import vproc_cache_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_BIT_W      = 16,
  parameter int unsigned CPU_BYTE_W      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*ADDR_BIT_W-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*CPU_BYTE_W-1:0]   be_i,
  input  logic [NUM_REQ*CPU_BYTE_W*8-1:0] wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [CPU_BYTE_W*8-1:0]         rdata_o,
  output logic                            err_o,
  output logic                            cache_req_o,
  output logic [ADDR_BIT_W-1:0]           cache_addr_o,
  output logic                            cache_we_o,
  output logic [CPU_BYTE_W-1:0]           cache_be_o,
  output logic [CPU_BYTE_W*8-1:0]         cache_wdata_o,
  input  logic                            cache_gnt_i,
  input  logic                            cache_rvalid_i,
  input  logic [CPU_BYTE_W*8-1:0]         cache_rdata_i,
  input  logic                            cache_err_i,
  output logic [NUM_REQ*32-1:0]           perf_gnt_cnt_o
);

  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned DATA_W   = CPU_BYTE_W * 8;

  logic [ID_WIDTH-1:0] rr_q, sel_c, head_id;
  logic                fifo_full, fifo_empty, hs_c, pop_c;

  // Selection ignores cache_gnt_i so no combinational loop through the cache.
  assign sel_c = ID_WIDTH'(rr_select(RR_MAX_REQ'(req_i), NUM_REQ, 32'(rr_q)));

  assign cache_req_o = (|req_i) & ~fifo_full;
  assign hs_c        = cache_req_o & cache_gnt_i;
  // A response with no outstanding ID is dropped.
  assign pop_c       = cache_rvalid_i & ~fifo_empty;

  assign rdata_o = cache_rdata_i;
  assign err_o   = cache_err_i;

  // Payload mux and per-requester grant/response decode.
  always_comb begin
    cache_addr_o  = '0;
    cache_we_o    = 1'b0;
    cache_be_o    = '0;
    cache_wdata_o = '0;
    gnt_o         = '0;
    rvalid_o      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_c == ID_WIDTH'(i)) begin
        cache_addr_o  = addr_i[i*ADDR_BIT_W +: ADDR_BIT_W];
        cache_we_o    = we_i[i];
        cache_be_o    = be_i[i*CPU_BYTE_W +: CPU_BYTE_W];
        cache_wdata_o = wdata_i[i*DATA_W +: DATA_W];
        gnt_o[i]      = hs_c;
      end
      if (head_id == ID_WIDTH'(i)) rvalid_o[i] = pop_c;
    end
  end

  // Priority pointer moves past the winner only on a handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (hs_c) begin
      rr_q <= (sel_c == ID_WIDTH'(NUM_REQ - 1)) ? '0 : sel_c + 1'b1;
    end
  end

  vproc_cache_arb_idfifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (ID_WIDTH)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs_c),
    .data_i  (sel_c),
    .pop_i   (pop_c),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef VPROC_CACHE_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_o[i]) perf_q[i] <= perf_q[i] + 32'd1;
      end
    end
  end

  assign perf_gnt_cnt_o = perf_q;
`else
  assign perf_gnt_cnt_o = '0;
`endif

  // A cache response with nothing outstanding is a protocol violation.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(cache_rvalid_i && fifo_empty));

endmodule
